// File: rtl/gmii_tx_arbiter_pkg.sv
// Shared definitions for the two-source GMII transmit arbiter: FSM state
// encoding, default timing constants, channel indices and counter widths.
package gmii_tx_arbiter_pkg;

  // 3-bit state encoding.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_GRANT  = 3'd1;
  localparam logic [2:0] ST_ACTIVE = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_IFG    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_GRANT  = ST_GRANT,
    S_ACTIVE = ST_ACTIVE,
    S_DRAIN  = ST_DRAIN,
    S_IFG    = ST_IFG
  } state_e;

  // Default timing limits, in gmii_tx_clk cycles.
  localparam int DEF_IFG_CYCLES    = 12;
  localparam int DEF_START_TIMEOUT = 64;
  localparam int DEF_MAX_FRAME     = 1600;

  // Channel indices: channel 0 carries ARP, channel 1 carries UDP.
  localparam logic CH_ARP = 1'b0;
  localparam logic CH_UDP = 1'b1;

  // Counter widths sized for the largest legal parameter values.
  localparam int START_CNT_W = 10;
  localparam int LEN_CNT_W   = 11;
  localparam int IFG_CNT_W   = 8;

endpackage

// File: rtl/gmii_rr_pick.sv
// Two-way round-robin selector. A lone requester wins outright; on a tie the
// channel that did not own the path last time wins.
module gmii_rr_pick
  import gmii_tx_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  // Pure combinational choice; the caller registers the result.
  always_comb begin
    valid  = req0 | req1;
    winner = CH_ARP;
    if (req0 && req1) begin
      winner = ~last_owner;
    end else if (req1) begin
      winner = CH_UDP;
    end
  end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Shares one GMII transmit path between an ARP source (channel 0) and a UDP
// source (channel 1). The owner's byte stream is forwarded through one
// register stage; the FSM enforces a minimum inter-frame gap, revokes grants
// that never start, and truncates frames that run past MAX_FRAME.
//
// Handshake: reqN is a level request. grantN high means channel N owns the
// path; the owner raises srcN_en to start its frame and lowers it to end it.
// The grant falls on the same edge that samples srcN_en low. Inputs of the
// channel that does not own the path are ignored.
module gmii_tx_arbiter
  import gmii_tx_arbiter_pkg::*;
#(
  parameter int IFG_CYCLES    = DEF_IFG_CYCLES,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int MAX_FRAME     = DEF_MAX_FRAME
) (
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       src0_en,
  input  logic [7:0] src0_txd,
  input  logic       req1,
  input  logic       src1_en,
  input  logic [7:0] src1_txd,
  output logic       grant0,
  output logic       grant1,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_overlen
);

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_owner_q, last_owner_d;
  logic [START_CNT_W-1:0] start_cnt_q, start_cnt_d;
  logic [LEN_CNT_W-1:0]   len_cnt_q, len_cnt_d;
  logic [IFG_CNT_W-1:0]   ifg_cnt_q, ifg_cnt_d;
  logic                   out_en_q, out_en_d;
  logic [7:0]             out_txd_q, out_txd_d;
  logic                   err_to_q, err_to_d;
  logic                   err_ov_q, err_ov_d;

  logic                   pick_valid;
  logic                   pick_winner;
  logic                   own_en;
  logic [7:0]             own_txd;
  logic [START_CNT_W-1:0] start_cnt_inc;
  logic                   holds_path;

  gmii_rr_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Select the owner's GMII inputs; the other channel never reaches the output.
  always_comb begin
    own_en        = (owner_q == CH_UDP) ? src1_en  : src0_en;
    own_txd       = (owner_q == CH_UDP) ? src1_txd : src0_txd;
    start_cnt_inc = start_cnt_q + 1'b1;
  end

  // Next-state, counters and next output byte; idle output is the default.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    start_cnt_d  = start_cnt_q;
    len_cnt_d    = len_cnt_q;
    ifg_cnt_d    = ifg_cnt_q;
    out_en_d     = 1'b0;
    out_txd_d    = 8'h00;
    err_to_d     = 1'b0;
    err_ov_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d      = S_GRANT;
          owner_d      = pick_winner;
          last_owner_d = pick_winner;
          start_cnt_d  = '0;
        end
      end
      S_GRANT: begin
        if (own_en) begin
          state_d   = S_ACTIVE;
          out_en_d  = 1'b1;
          out_txd_d = own_txd;
          len_cnt_d = LEN_CNT_W'(1);
        end else if (start_cnt_inc == START_CNT_W'(START_TIMEOUT)) begin
          state_d     = S_IDLE;
          start_cnt_d = '0;
          err_to_d    = 1'b1;
        end else begin
          start_cnt_d = start_cnt_inc;
        end
      end
      S_ACTIVE: begin
        if (!own_en) begin
          state_d   = S_IFG;
          ifg_cnt_d = '0;
        end else if (len_cnt_q == LEN_CNT_W'(MAX_FRAME)) begin
          // Already forwarded MAX_FRAME bytes: cut the frame off here.
          state_d  = S_DRAIN;
          err_ov_d = 1'b1;
        end else begin
          out_en_d  = 1'b1;
          out_txd_d = own_txd;
          len_cnt_d = len_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!own_en) begin
          state_d   = S_IFG;
          ifg_cnt_d = '0;
        end
      end
      S_IFG: begin
        if (ifg_cnt_q == IFG_CNT_W'(IFG_CYCLES - 1)) begin
          state_d   = S_IDLE;
          ifg_cnt_d = '0;
        end else begin
          ifg_cnt_d = ifg_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and the registered output stage.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= CH_ARP;
      last_owner_q <= CH_UDP;
      start_cnt_q  <= '0;
      len_cnt_q    <= '0;
      ifg_cnt_q    <= '0;
      out_en_q     <= 1'b0;
      out_txd_q    <= 8'h00;
      err_to_q     <= 1'b0;
      err_ov_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      start_cnt_q  <= start_cnt_d;
      len_cnt_q    <= len_cnt_d;
      ifg_cnt_q    <= ifg_cnt_d;
      out_en_q     <= out_en_d;
      out_txd_q    <= out_txd_d;
      err_to_q     <= err_to_d;
      err_ov_q     <= err_ov_d;
    end
  end

  // Grants and busy decode straight from registered state.
  always_comb begin
    holds_path  = (state_q == S_GRANT) || (state_q == S_ACTIVE) ||
                  (state_q == S_DRAIN);
    grant0      = holds_path && (owner_q == CH_ARP);
    grant1      = holds_path && (owner_q == CH_UDP);
    busy        = (state_q != S_IDLE);
    gmii_tx_en  = out_en_q;
    gmii_txd    = out_txd_q;
    err_timeout = err_to_q;
    err_overlen = err_ov_q;
  end

endmodule
